// File: rtl/serial_tx_pkg.sv
// Shared encodings for the serial transmitter and the logic that hooks it to
// the 4-bit universal shift register.
package serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    // Receiver mode select while SE is high: shift right, serial in.
    localparam logic [1:0] MODE_SHR_SI = 2'b11;

    function automatic int unsigned div_width(input int unsigned clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 and raises a registered tick
// for the cycle in which the count sits at its terminal value.
module bit_timer
    import serial_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    input  logic arm_i,
    output logic tick_o
);

    localparam int unsigned      DIV_W = div_width(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0] TERM  = DIV_W'(CLKS_PER_BIT - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = (cnt_q == TERM) ? '0 : cnt_q + DIV_W'(1);
    end

    // The tick is computed from the next count so it lines up with the cycle
    // the count is actually at TERM; arm_i says that cycle is a shift cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= arm_i && (cnt_d == TERM);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/serial_tx.sv
// Parallel-in, serial-out transmitter: sends a captured word LSB-first on SO
// with one SE strobe per bit, then a single-cycle done pulse.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] D,
    output logic             busy,
    output logic             SO,
    output logic             SE,
    output logic             done
);

    localparam int unsigned     BC_W     = $clog2(WIDTH + 1);
    localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [BC_W-1:0]  bitcnt_q;
    logic             busy_q, so_q, done_q;

    logic accept, in_shift, bit_end, last_bit, arm, tick;

    assign in_shift = (state_q == ST_SHIFT);
    assign accept   = (state_q == ST_IDLE) && start;
    assign bit_end  = in_shift && tick;
    assign last_bit = (bitcnt_q == LAST_BIT);
    assign shadow_d = shadow_q >> 1;

    // Next cycle is a shift cycle unless we just finished the final bit.
    assign arm = accept || (in_shift && !(bit_end && last_bit));

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr_i (!in_shift),
        .en_i  (in_shift),
        .arm_i (arm),
        .tick_o(tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            shadow_q <= '0;
            bitcnt_q <= '0;
            busy_q   <= 1'b0;
            so_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        shadow_q <= D;
                        bitcnt_q <= '0;
                        so_q     <= D[0];
                        busy_q   <= 1'b1;
                        state_q  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        shadow_q <= shadow_d;
                        bitcnt_q <= bitcnt_q + BC_W'(1);
                        if (last_bit) begin
                            so_q    <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            so_q <= shadow_d[0];
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    so_q    <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign SO   = so_q;
    assign SE   = tick;
    assign done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: two instances (1 and 3 clocks per bit), each
// feeding a behavioural 4-bit shift register running in shift-right mode.
module tb_serial_tx;
    import serial_tx_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start1 = 1'b1, start3 = 1'b0;
    logic [3:0] d1 = 4'b0011, d3 = 4'b0000;
    logic       busy1, so1, se1, done1;
    logic       busy3, so3, se3, done3;
    logic [3:0] q1, q3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_tx #(.WIDTH(4), .CLKS_PER_BIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .D(d1),
        .busy(busy1), .SO(so1), .SE(se1), .done(done1)
    );

    serial_tx #(.WIDTH(4), .CLKS_PER_BIT(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .D(d3),
        .busy(busy3), .SO(so3), .SE(se3), .done(done3)
    );

    // Receiving registers: M = {SE,SE}; shift-right/serial-in when M == 11.
    always_ff @(posedge clk) begin
        if (reset) begin
            q1 <= '0;
            q3 <= '0;
        end else begin
            if ({se1, se1} == MODE_SHR_SI) q1 <= {so1, q1[3:1]};
            if ({se3, se3} == MODE_SHR_SI) q3 <= {so3, q3[3:1]};
        end
    end

    // Expected {busy,SO,SE,done} in cycle c after the accepting edge.
    function automatic logic [3:0] exp_out(input int c, input int p, input logic [3:0] w);
        if (c >= 1 && c <= 4 * p)
            return {1'b1, w[(c - 1) / p], ((c % p) == 0), 1'b0};
        else if (c == 4 * p + 1)
            return 4'b1001;
        else
            return 4'b0000;
    endfunction

    task automatic test_reset;
        logic [3:0] e;
        // reset and start both high from time 0 for three edges
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy1, so1, se1, done1} !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got %b want 0000", i, {busy1, so1, se1, done1});
            end
        end
        reset = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            e = exp_out(c, 1, 4'b0011);
            checks++;
            if ({busy1, so1, se1, done1} !== e) begin
                errors++;
                $display("FAIL reset_first cyc%0d got %b want %b", c, {busy1, so1, se1, done1}, e);
            end
        end
    endtask

    task automatic test_basic;
        logic [3:0] e;
        start1 = 1'b1; d1 = 4'b1011;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start1 = 1'b0; d1 = 4'b0000;
            e = exp_out(c, 1, 4'b1011);
            checks++;
            if ({busy1, so1, se1, done1} !== e) begin
                errors++;
                $display("FAIL basic cyc%0d got %b want %b", c, {busy1, so1, se1, done1}, e);
            end
            if (c == 5) begin
                checks++;
                if (q1 !== 4'b1011) begin
                    errors++;
                    $display("FAIL basic_rx got %b want 1011", q1);
                end
            end
        end
    endtask

    task automatic test_slow;
        logic [3:0] e;
        start3 = 1'b1; d3 = 4'b0110;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start3 = 1'b0; d3 = 4'b1111;
            e = exp_out(c, 3, 4'b0110);
            checks++;
            if ({busy3, so3, se3, done3} !== e) begin
                errors++;
                $display("FAIL slow cyc%0d got %b want %b", c, {busy3, so3, se3, done3}, e);
            end
            if (c == 13) begin
                checks++;
                if (q3 !== 4'b0110) begin
                    errors++;
                    $display("FAIL slow_rx got %b want 0110", q3);
                end
            end
        end
    endtask

    task automatic test_held_start;
        logic [3:0] e;
        start1 = 1'b1; d1 = 4'b1001;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            // D changes every cycle; the value at edge 6 is 1001^0110 = 1111
            d1 = 4'b1001 ^ 4'(c);
            if (c == 11) start1 = 1'b0;
            e = (c <= 6) ? exp_out(c, 1, 4'b1001) : exp_out(c - 6, 1, 4'b1111);
            checks++;
            if ({busy1, so1, se1, done1} !== e) begin
                errors++;
                $display("FAIL held_start cyc%0d got %b want %b", c, {busy1, so1, se1, done1}, e);
            end
            if (c == 5 || c == 11) begin
                checks++;
                if (q1 !== ((c == 5) ? 4'b1001 : 4'b1111)) begin
                    errors++;
                    $display("FAIL held_rx cyc%0d got %b", c, q1);
                end
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [3:0] e;
        start1 = 1'b1; d1 = 4'b1111;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (c == 2) reset = 1'b1;
            if (c == 3) reset = 1'b0;
            e = (c <= 2) ? exp_out(c, 1, 4'b1111) : 4'b0000;
            checks++;
            if ({busy1, so1, se1, done1} !== e) begin
                errors++;
                $display("FAIL abort cyc%0d got %b want %b", c, {busy1, so1, se1, done1}, e);
            end
        end
        start1 = 1'b1; d1 = 4'b0101;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start1 = 1'b0;
            e = exp_out(c, 1, 4'b0101);
            checks++;
            if ({busy1, so1, se1, done1} !== e) begin
                errors++;
                $display("FAIL abort_next cyc%0d got %b want %b", c, {busy1, so1, se1, done1}, e);
            end
            if (c == 5) begin
                checks++;
                if (q1 !== 4'b0101) begin
                    errors++;
                    $display("FAIL abort_rx got %b want 0101", q1);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] e;
        int se_a = 0, se_b = 0, idle_cnt = 0;
        start1 = 1'b1; d1 = 4'b0000;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 6) d1 = 4'b1111;
            if (c == 7) start1 = 1'b0;
            e = (c <= 6) ? exp_out(c, 1, 4'b0000) : exp_out(c - 6, 1, 4'b1111);
            checks++;
            if ({busy1, so1, se1, done1} !== e) begin
                errors++;
                $display("FAIL b2b cyc%0d got %b want %b", c, {busy1, so1, se1, done1}, e);
            end
            if (se1 === 1'b1) begin
                if (c <= 6) se_a++; else se_b++;
            end
            if (c <= 11 && busy1 !== 1'b1) idle_cnt++;
        end
        checks++;
        if (se_a != 4 || se_b != 4) begin
            errors++;
            $display("FAIL b2b_se_count got %0d/%0d want 4/4", se_a, se_b);
        end
        checks++;
        if (idle_cnt != 1) begin
            errors++;
            $display("FAIL b2b_gap got %0d idle cycles want 1", idle_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow();
        test_held_start();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
